// File: rtl/axi_rd_scheduler.sv
// Arbitrates the Icache (IFU) and LSU read channels onto a single AXI read master.
// Round-robin between requesters; LSU reads are held back behind any pending write.
module axi_rd_scheduler #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int SIZE_W = 3,
    parameter int TMO    = 1023
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              ifu_r_valid_i,
    input  logic [ADDR_W-1:0] ifu_r_addr_i,
    input  logic [LEN_W-1:0]  ifu_r_len_i,
    output logic              ifu_r_ready_o,
    output logic [DATA_W-1:0] ifu_r_data_o,
    output logic              ifu_r_last_o,
    input  logic              lsu_r_valid_i,
    input  logic [ADDR_W-1:0] lsu_r_addr_i,
    input  logic [SIZE_W-1:0] lsu_r_size_i,
    input  logic [LEN_W-1:0]  lsu_r_len_i,
    output logic              lsu_r_ready_o,
    output logic [DATA_W-1:0] lsu_r_data_o,
    output logic              lsu_r_last_o,
    input  logic              lsu_w_valid_i,
    output logic              down_r_valid_o,
    output logic [ADDR_W-1:0] down_r_addr_o,
    output logic [SIZE_W-1:0] down_r_size_o,
    output logic [LEN_W-1:0]  down_r_len_o,
    input  logic              down_r_ready_i,
    input  logic [DATA_W-1:0] down_r_data_i,
    input  logic              down_r_last_i,
    input  logic              down_w_ready_i,
    input  logic              down_w_last_i,
    output logic [1:0]        grant_o,
    output logic              tmo_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        G_IFU = 2'b01,
        G_LSU = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam int CNT_W = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

    state_t           state_q;
    logic             ptr_q;
    logic             wr_busy_q;
    logic             wr_busy_d;
    logic [CNT_W-1:0] cnt_q;
    logic             tmo_err_q;

    logic ifu_elig;
    logic lsu_elig;
    logic pick_lsu;
    logic rd_done;

    assign ifu_elig = ifu_r_valid_i;
    assign lsu_elig = lsu_r_valid_i & ~wr_busy_q & ~lsu_w_valid_i;
    assign pick_lsu = lsu_elig & (~ifu_elig | ptr_q);
    assign rd_done  = down_r_ready_i & down_r_last_i;

    // Write completion dominates a new write request in the same cycle.
    assign wr_busy_d = (down_w_ready_i & down_w_last_i) ? 1'b0 :
                       (lsu_w_valid_i ? 1'b1 : wr_busy_q);

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            wr_busy_q <= 1'b0;
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            wr_busy_q <= wr_busy_d;
            case (state_q)
                IDLE: begin
                    if (ifu_elig | lsu_elig) begin
                        cnt_q   <= '0;
                        state_q <= pick_lsu ? G_LSU : G_IFU;
                    end
                end
                G_IFU, G_LSU: begin
                    if (rd_done) begin
                        state_q <= IDLE;
                        ptr_q   <= (state_q == G_IFU);
                    end else if (down_r_ready_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == TMO_C) begin
                        state_q   <= HALT;
                        tmo_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read channels are pure muxes keyed on the registered grant; reset forces them low.
    always_comb begin
        down_r_valid_o = 1'b0;
        down_r_addr_o  = '0;
        down_r_size_o  = '0;
        down_r_len_o   = '0;
        ifu_r_ready_o  = 1'b0;
        ifu_r_data_o   = '0;
        ifu_r_last_o   = 1'b0;
        lsu_r_ready_o  = 1'b0;
        lsu_r_data_o   = '0;
        lsu_r_last_o   = 1'b0;
        if (areset_n) begin
            case (state_q)
                G_IFU: begin
                    down_r_valid_o = ifu_r_valid_i;
                    down_r_addr_o  = ifu_r_addr_i;
                    down_r_size_o  = SIZE_W'(3'b010);
                    down_r_len_o   = ifu_r_len_i;
                    ifu_r_ready_o  = down_r_ready_i;
                    ifu_r_data_o   = down_r_data_i;
                    ifu_r_last_o   = down_r_last_i;
                end
                G_LSU: begin
                    down_r_valid_o = lsu_r_valid_i;
                    down_r_addr_o  = lsu_r_addr_i;
                    down_r_size_o  = lsu_r_size_i;
                    down_r_len_o   = lsu_r_len_i;
                    lsu_r_ready_o  = down_r_ready_i;
                    lsu_r_data_o   = down_r_data_i;
                    lsu_r_last_o   = down_r_last_i;
                end
                default: ;
            endcase
        end
    end

    assign grant_o   = areset_n ? state_q : 2'b00;
    assign tmo_err_o = areset_n & tmo_err_q;

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Directed bench for axi_rd_scheduler: arbitration, write blocking, timeout, reset abort.
module tb_axi_rd_scheduler;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;
    localparam int TMO    = 1023;

    logic              aclk;
    logic              areset_n;
    logic              ifu_r_valid_i;
    logic [ADDR_W-1:0] ifu_r_addr_i;
    logic [LEN_W-1:0]  ifu_r_len_i;
    logic              ifu_r_ready_o;
    logic [DATA_W-1:0] ifu_r_data_o;
    logic              ifu_r_last_o;
    logic              lsu_r_valid_i;
    logic [ADDR_W-1:0] lsu_r_addr_i;
    logic [SIZE_W-1:0] lsu_r_size_i;
    logic [LEN_W-1:0]  lsu_r_len_i;
    logic              lsu_r_ready_o;
    logic [DATA_W-1:0] lsu_r_data_o;
    logic              lsu_r_last_o;
    logic              lsu_w_valid_i;
    logic              down_r_valid_o;
    logic [ADDR_W-1:0] down_r_addr_o;
    logic [SIZE_W-1:0] down_r_size_o;
    logic [LEN_W-1:0]  down_r_len_o;
    logic              down_r_ready_i;
    logic [DATA_W-1:0] down_r_data_i;
    logic              down_r_last_i;
    logic              down_w_ready_i;
    logic              down_w_last_i;
    logic [1:0]        grant_o;
    logic              tmo_err_o;

    int total;
    int bad;

    axi_rd_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W), .TMO(TMO)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_len_i(ifu_r_len_i),
        .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o), .ifu_r_last_o(ifu_r_last_o),
        .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i), .lsu_r_size_i(lsu_r_size_i),
        .lsu_r_len_i(lsu_r_len_i),
        .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o), .lsu_r_last_o(lsu_r_last_o),
        .lsu_w_valid_i(lsu_w_valid_i),
        .down_r_valid_o(down_r_valid_o), .down_r_addr_o(down_r_addr_o),
        .down_r_size_o(down_r_size_o), .down_r_len_o(down_r_len_o),
        .down_r_ready_i(down_r_ready_i), .down_r_data_i(down_r_data_i),
        .down_r_last_i(down_r_last_i),
        .down_w_ready_i(down_w_ready_i), .down_w_last_i(down_w_last_i),
        .grant_o(grant_o), .tmo_err_o(tmo_err_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        areset_n = 1'b0;
        ifu_r_valid_i = 1'b1; ifu_r_addr_i = '0; ifu_r_len_i = '0;
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = '0; lsu_r_size_i = '0; lsu_r_len_i = '0;
        lsu_w_valid_i = 1'b0;
        down_r_ready_i = 1'b1; down_r_data_i = 32'hDEAD_BEEF; down_r_last_i = 1'b1;
        down_w_ready_i = 1'b0; down_w_last_i = 1'b0;

        // Reset with active inputs: every output must stay low.
        tick(); tick(); settle();
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_tmo", tmo_err_o, 1'b0);
        chk("rst_dvalid", down_r_valid_o, 1'b0);
        chk("rst_ifu_rdy", ifu_r_ready_o, 1'b0);
        chk("rst_lsu_rdy", lsu_r_ready_o, 1'b0);
        ifu_r_valid_i = 1'b0; lsu_r_valid_i = 1'b0;
        down_r_ready_i = 1'b0; down_r_last_i = 1'b0;
        areset_n = 1'b1;
        tick();

        // IFU-only 4-beat burst; ready starts one cycle after the grant.
        ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0000; ifu_r_len_i = 8'd3;
        settle();
        chk("a_idle_grant", grant_o, 2'b00);
        chk("a_idle_dvalid", down_r_valid_o, 1'b0);
        tick(); settle();
        chk("a_grant", grant_o, 2'b01);
        chk("a_dvalid", down_r_valid_o, 1'b1);
        chk("a_daddr", down_r_addr_o, 32'h8000_0000);
        chk("a_dlen", down_r_len_o, 8'd3);
        chk("a_dsize", down_r_size_o, 3'b010);
        chk("a_ifu_rdy0", ifu_r_ready_o, 1'b0);
        tick();
        for (int b = 0; b < 4; b++) begin
            down_r_ready_i = 1'b1;
            down_r_data_i  = 32'hA000_0000 + 32'(b);
            down_r_last_i  = (b == 3);
            settle();
            chk("a_beat_grant", grant_o, 2'b01);
            chk("a_ifu_rdy", ifu_r_ready_o, 1'b1);
            chk("a_ifu_data", ifu_r_data_o, 32'hA000_0000 + 32'(b));
            chk("a_ifu_last", ifu_r_last_o, (b == 3));
            chk("a_lsu_rdy", lsu_r_ready_o, 1'b0);
            tick();
        end
        down_r_ready_i = 1'b0; down_r_last_i = 1'b0; ifu_r_valid_i = 1'b0;
        settle();
        chk("a_done_grant", grant_o, 2'b00);
        chk("a_done_ifu_rdy", ifu_r_ready_o, 1'b0);
        tick();

        // Pointer now prefers LSU; then IFU wins at pointer 0; dead cycle between grants.
        ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h100; ifu_r_len_i = 8'd0;
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h200; lsu_r_size_i = 3'd1; lsu_r_len_i = 8'd0;
        settle();
        chk("b_idle", grant_o, 2'b00);
        tick(); settle();
        chk("b_grant_lsu", grant_o, 2'b10);
        chk("b_daddr_lsu", down_r_addr_o, 32'h200);
        chk("b_dsize_lsu", down_r_size_o, 3'd1);
        down_r_ready_i = 1'b1; down_r_last_i = 1'b1; down_r_data_i = 32'h55;
        settle();
        chk("b_lsu_rdy", lsu_r_ready_o, 1'b1);
        chk("b_lsu_data", lsu_r_data_o, 32'h55);
        chk("b_lsu_last", lsu_r_last_o, 1'b1);
        chk("b_ifu_rdy_off", ifu_r_ready_o, 1'b0);
        tick();
        lsu_r_addr_i = 32'h300; down_r_ready_i = 1'b0; down_r_last_i = 1'b0;
        settle();
        chk("b_dead1", grant_o, 2'b00);
        tick(); settle();
        chk("b_grant_ifu", grant_o, 2'b01);
        chk("b_daddr_ifu", down_r_addr_o, 32'h100);
        down_r_ready_i = 1'b1; down_r_last_i = 1'b1; down_r_data_i = 32'h66;
        settle();
        chk("b_ifu_rdy", ifu_r_ready_o, 1'b1);
        chk("b_ifu_data", ifu_r_data_o, 32'h66);
        chk("b_lsu_rdy_off", lsu_r_ready_o, 1'b0);
        tick();
        ifu_r_valid_i = 1'b0; down_r_ready_i = 1'b0; down_r_last_i = 1'b0;
        settle();
        chk("b_dead2", grant_o, 2'b00);
        tick(); settle();
        chk("b_grant_lsu2", grant_o, 2'b10);
        chk("b_daddr_lsu2", down_r_addr_o, 32'h300);
        down_r_ready_i = 1'b1; down_r_last_i = 1'b1;
        settle();
        chk("b_lsu_rdy2", lsu_r_ready_o, 1'b1);
        tick();
        lsu_r_valid_i = 1'b0; down_r_ready_i = 1'b0; down_r_last_i = 1'b0;
        settle();
        chk("b_end", grant_o, 2'b00);
        tick();

        // LSU read waits for the write-last handshake 5 cycles after the write; IFU proceeds.
        lsu_w_valid_i = 1'b1;
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h400; lsu_r_size_i = 3'd2; lsu_r_len_i = 8'd0;
        settle();
        chk("c0_grant", grant_o, 2'b00);
        tick();
        lsu_w_valid_i = 1'b0;
        ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h180; ifu_r_len_i = 8'd0;
        settle();
        chk("c1_grant", grant_o, 2'b00);
        tick();
        down_r_ready_i = 1'b1; down_r_last_i = 1'b1; down_r_data_i = 32'h11;
        settle();
        chk("c2_grant_ifu", grant_o, 2'b01);
        chk("c2_ifu_rdy", ifu_r_ready_o, 1'b1);
        tick();
        ifu_r_valid_i = 1'b0; down_r_ready_i = 1'b0; down_r_last_i = 1'b0;
        settle();
        chk("c3_grant", grant_o, 2'b00);
        tick(); settle();
        chk("c4_grant", grant_o, 2'b00);
        tick();
        down_w_ready_i = 1'b1; down_w_last_i = 1'b1;
        settle();
        chk("c5_grant", grant_o, 2'b00);
        tick();
        down_w_ready_i = 1'b0; down_w_last_i = 1'b0;
        settle();
        chk("c6_grant", grant_o, 2'b00);
        tick(); settle();
        chk("c7_grant_lsu", grant_o, 2'b10);
        chk("c7_dsize", down_r_size_o, 3'd2);
        chk("c7_dlen", down_r_len_o, 8'd0);
        down_r_ready_i = 1'b1; down_r_last_i = 1'b1; down_r_data_i = 32'h77;
        settle();
        chk("c7_lsu_data", lsu_r_data_o, 32'h77);
        chk("c7_ifu_rdy_off", ifu_r_ready_o, 1'b0);
        tick();
        lsu_r_valid_i = 1'b0; down_r_ready_i = 1'b0; down_r_last_i = 1'b0;
        settle();
        chk("c8_grant", grant_o, 2'b00);
        tick();

        // Write set and write-last clear in the same cycle leave the LSU unblocked.
        lsu_w_valid_i = 1'b1; down_w_ready_i = 1'b1; down_w_last_i = 1'b1;
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h500; lsu_r_len_i = 8'd10;
        settle();
        chk("c9_grant", grant_o, 2'b00);
        tick();
        lsu_w_valid_i = 1'b0; down_w_ready_i = 1'b0; down_w_last_i = 1'b0;
        settle();
        chk("c10_grant", grant_o, 2'b00);
        tick(); settle();
        chk("c11_grant_lsu", grant_o, 2'b10);

        // Beats without last keep the grant and restart the timeout window.
        for (int i = 0; i < 10; i++) begin
            down_r_ready_i = 1'b1; down_r_last_i = 1'b0;
            settle();
            chk("d_beat_grant", grant_o, 2'b10);
            chk("d_beat_rdy", lsu_r_ready_o, 1'b1);
            tick();
        end
        down_r_ready_i = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        settle();
        chk("d_gap1_grant", grant_o, 2'b10);
        chk("d_gap1_tmo", tmo_err_o, 1'b0);
        down_r_ready_i = 1'b1;
        tick();
        down_r_ready_i = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        settle();
        chk("d_gap2_grant", grant_o, 2'b10);
        chk("d_gap2_tmo", tmo_err_o, 1'b0);
        down_r_ready_i = 1'b1; down_r_last_i = 1'b1;
        tick();
        lsu_r_valid_i = 1'b0; down_r_ready_i = 1'b0; down_r_last_i = 1'b0;
        settle();
        chk("d_end", grant_o, 2'b00);
        tick();

        // No beat for TMO cycles: HALT with sticky error until reset.
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h600; lsu_r_len_i = 8'd0;
        tick(); settle();
        chk("e_grant", grant_o, 2'b10);
        for (int i = 0; i < TMO; i++) tick();
        settle();
        chk("e_pre_grant", grant_o, 2'b10);
        chk("e_pre_tmo", tmo_err_o, 1'b0);
        tick();
        ifu_r_valid_i = 1'b1; down_r_ready_i = 1'b1; down_r_last_i = 1'b1;
        settle();
        chk("e_halt_grant", grant_o, 2'b11);
        chk("e_halt_tmo", tmo_err_o, 1'b1);
        chk("e_halt_dvalid", down_r_valid_o, 1'b0);
        chk("e_halt_lsu_rdy", lsu_r_ready_o, 1'b0);
        chk("e_halt_ifu_rdy", ifu_r_ready_o, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        settle();
        chk("e_hold_grant", grant_o, 2'b11);
        chk("e_hold_tmo", tmo_err_o, 1'b1);
        areset_n = 1'b0;
        settle();
        chk("e_inrst_grant", grant_o, 2'b00);
        chk("e_inrst_tmo", tmo_err_o, 1'b0);
        tick();
        areset_n = 1'b1;
        ifu_r_valid_i = 1'b0; lsu_r_valid_i = 1'b0;
        down_r_ready_i = 1'b0; down_r_last_i = 1'b0;
        settle();
        chk("e_post_grant", grant_o, 2'b00);
        chk("e_post_tmo", tmo_err_o, 1'b0);
        tick();

        // Reset during beat 2 of an IFU burst aborts without a completion pulse.
        ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h700; ifu_r_len_i = 8'd3;
        tick(); settle();
        chk("f_grant", grant_o, 2'b01);
        down_r_ready_i = 1'b1; down_r_last_i = 1'b0; down_r_data_i = 32'h71;
        settle();
        chk("f_beat1_rdy", ifu_r_ready_o, 1'b1);
        tick();
        areset_n = 1'b0; down_r_data_i = 32'h72;
        settle();
        chk("f_inrst_rdy", ifu_r_ready_o, 1'b0);
        tick();
        areset_n = 1'b1;
        settle();
        chk("f_post_grant", grant_o, 2'b00);
        chk("f_post_rdy", ifu_r_ready_o, 1'b0);
        chk("f_post_tmo", tmo_err_o, 1'b0);
        ifu_r_valid_i = 1'b0; down_r_ready_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_scheduler.md
AXI_RD_SCHEDULER -- requirements
Module: ysyx_23060077_axi_rd_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter LEN_W, 8, burst length width.
REQ-004 SHALL have parameter SIZE_W, 3, transfer size width.
REQ-005 SHALL have parameter TMO, 1023, cycles without a read beat before timeout.
REQ-006 SHALL have port aclk, input, 1, clock.
REQ-007 SHALL have port areset_n, input, 1, reset (synchronous, active-low).
REQ-008 SHALL have ports ifu_r_valid_i/addr_i/len_i as inputs (1/ADDR_W/LEN_W), the Icache read request.
REQ-009 SHALL have ports ifu_r_ready_o/data_o/last_o as outputs (1/DATA_W/1), the Icache read response.
REQ-010 SHALL have ports lsu_r_valid_i/addr_i/size_i/len_i as inputs (1/ADDR_W/SIZE_W/LEN_W), the LSU read request.
REQ-011 SHALL have ports lsu_r_ready_o/data_o/last_o as outputs (1/DATA_W/1), the LSU read response.
REQ-012 SHALL have port lsu_w_valid_i, input, 1, LSU write request (observed only).
REQ-013 SHALL have ports down_r_valid_o/addr_o/size_o/len_o as outputs (1/ADDR_W/SIZE_W/LEN_W), the read request to the AXI master.
REQ-014 SHALL have ports down_r_ready_i/data_i/last_i as inputs (1/DATA_W/1), the per-beat read response from the AXI master.
REQ-015 SHALL have ports down_w_ready_i and down_w_last_i, inputs, 1 each, write beat completion from the AXI master.
REQ-016 SHALL have port grant_o, output, 2, state: 00 idle, 01 IFU, 10 LSU.
REQ-017 SHALL have port tmo_err_o, output, 1, sticky timeout flag.

Function
REQ-018 SHALL implement states IDLE, G_IFU, G_LSU, HALT, encoded as grant_o 00/01/10/11.
REQ-019 In IDLE, down_r_valid_o and all ifu_*/lsu_* read outputs SHALL be 0.
REQ-020 In G_IFU, down_r_valid_o/addr_o/len_o SHALL equal ifu_r_*, down_r_size_o SHALL be 3'b010, and ifu_r_ready_o/data_o/last_o SHALL equal down_r_*; lsu_r outputs SHALL be 0.
REQ-021 In G_LSU, down_r_* SHALL mirror lsu_r_* and lsu_r outputs SHALL mirror down_r_*; ifu_r outputs SHALL be 0.
REQ-022 The scheduler SHALL keep a 1-bit round-robin pointer (0 = IFU preferred, 1 = LSU preferred).
REQ-023 IDLE to grant SHALL take one cycle: with a request eligible at cycle N, the state is G_x at N+1.
REQ-024 If both requesters are eligible, the pointer SHALL select the winner.
REQ-025 LSU SHALL be eligible only when lsu_r_valid_i=1, wr_busy=0 and lsu_w_valid_i=0, so no read passes a pending write.
REQ-026 wr_busy SHALL set on lsu_w_valid_i=1 and clear on down_w_ready_i&down_w_last_i.
REQ-027 If set and clear occur in the same cycle, clear SHALL win.
REQ-028 A grant SHALL persist until down_r_ready_i&down_r_last_i, regardless of the other requester.
REQ-029 On that completion, the state SHALL return to IDLE next cycle, giving exactly one dead cycle between transactions.
REQ-030 On that completion, the pointer SHALL be set to prefer the non-granted requester.
REQ-031 Requester valid, addr, size and len SHALL be held stable by the requester until its own ready&last; the scheduler does not register them.
REQ-032 A cycle counter SHALL clear on entering G_x and on every down_r_ready_i=1 cycle.
REQ-033 The counter SHALL increment in G_x otherwise and saturate at TMO.
REQ-034 When the counter reaches TMO, the next state SHALL be HALT and tmo_err_o SHALL be set.
REQ-035 HALT SHALL drive all read outputs to 0 and stay until reset; tmo_err_o SHALL stay 1 until reset.
REQ-036 A len of 0 (single beat) SHALL complete on the first ready with last=1.
REQ-037 A down_r_ready_i that arrives without down_r_last_i SHALL NOT end the grant.

Reset
REQ-038 With areset_n=0 at a clock edge, the state SHALL become IDLE, pointer 0, wr_busy 0, counter 0 and tmo_err_o 0.
REQ-039 While in reset, all outputs SHALL be 0.
REQ-040 Reset mid-burst SHALL abort the grant without any completion pulse to either requester.

Verification
REQ-041 IFU only, len=3, down ready each cycle with last on beat 4 -> grant_o 01 from cycle 1, four ifu_r_ready_o pulses, 00 on cycle 6, pointer=1.
REQ-042 IFU and LSU valid in the same IDLE cycle with pointer 0 -> IFU granted; after completion, one idle cycle, then LSU granted.
REQ-043 LSU write then LSU read with down_w_last delayed 5 cycles -> LSU read not granted until the cycle after the write-last handshake; IFU is still granted meanwhile.
REQ-044 Grant to LSU with down_r_ready_i held 0 for TMO cycles -> HALT (grant_o 11), tmo_err_o=1; it persists until areset_n=0.
REQ-045 areset_n=0 during beat 2 of an IFU burst -> next cycle grant_o=00, ifu_r_ready_o=0 and tmo_err_o=0.
REQ-046 down_r_ready_i=1 with down_r_last_i=0 for 10 cycles -> grant held, counter cleared each beat, no timeout.
